hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Hazard and forwarding controller for the 5-stage pipeline. It is the opposite end of the
//  EX-stage forwarding interface: it consumes Rs_Hazard/Rt_Hazard/WriteReg_E from EX and
//  returns ForwardA_E/ForwardB_E. It drives stall/flush for F/D/E.
//  It keeps its own shadow copy of the M and W destination-register state.
//  It runs a busy counter for the multi-cycle multiply/divide unit.
// PARAMETERS
//  MULT_LAT  5   cycles MD_Busy stays high after a multiply start (legal range 1..63)
//  DIV_LAT   10  cycles MD_Busy stays high after a divide start (legal range 1..63)
// PORTS
//  clk         in   1  single clock, all state updates on rising edge
//  reset       in   1  synchronous, active-low reset
//  Rs_D        in   5  rs field of instruction in D
//  Rt_D        in   5  rt field of instruction in D
//  Branch_D    in   1  D instruction is beq/bne (compares Rs_D, Rt_D in D)
//  Jr_D        in   1  D instruction is jr/jalr (reads Rs_D in D)
//  MD_Use_D    in   1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
//  Rs_Hazard   in   5  rs of instruction in E
//  Rt_Hazard   in   5  rt of instruction in E
//  WriteReg_E  in   5  destination register of instruction in E
//  RegWrite_E  in   1  E instruction writes the register file
//  MemtoReg_E  in   1  E instruction is a load
//  MD_Start_E  in   1  E instruction starts mult/div this cycle
//  MD_Div_E    in   1  1 = divide, 0 = multiply (valid with MD_Start_E)
//  ForwardA_E  out  2  EX operand A select: 00 RD1, 01 ResultW, 10 ALU_O_M
//  ForwardB_E  out  2  EX operand B select, same encoding
//  ForwardA_D  out  1  D-stage compare operand A taken from M-stage ALU result
//  ForwardB_D  out  1  D-stage compare operand B taken from M-stage ALU result
//  Stall_F     out  1  hold PC
//  Stall_D     out  1  hold IF/ID register
//  Flush_E     out  1  load bubble into ID/EX register
//  MD_Busy     out  1  multiply/divide unit busy
// BEHAVIOUR
//  Shadow state (regs): {WriteReg_M,RegWrite_M,MemtoReg_M} <= {WriteReg_E,RegWrite_E,MemtoReg_E}
//   every cycle; {WriteReg_W,RegWrite_W} <= {WriteReg_M,RegWrite_M} every cycle. Advance is
//   unconditional: E->M never stalls, and a flushed E arrives with RegWrite_E=0.
//  Reset (reset==0 at edge): shadow cleared to 0; md_cnt <= 0. While reset is low, every output
//   is forced to 0. After release all outputs are 0 until inputs create a hazard.
//  Register $0 never matches: any compare with a source of 0 is false.
//  ForwardA_E: 10 if RegWrite_M && WriteReg_M==Rs_Hazard.
//   Else 01 if RegWrite_W && WriteReg_W==Rs_Hazard. Else 00. M has priority over W.
//   ForwardB_E is identical using Rt_Hazard.
//  ForwardA_D = RegWrite_M && WriteReg_M==Rs_D. ForwardB_D is the same using Rt_D.
//  lwstall = RegWrite_E && MemtoReg_E && WriteReg_E!=0 && (WriteReg_E==Rs_D || WriteReg_E==Rt_D).
//  brstall: applies when Branch_D or Jr_D is set, for each source read in D.
//   Sources read: Rs_D for both; Rt_D only for Branch_D.
//   Stall when (RegWrite_E && WriteReg_E==src) or (RegWrite_M && MemtoReg_M && WriteReg_M==src).
//  MD counter md_cnt[5:0]:
//   - If MD_Start_E: load DIV_LAT when MD_Div_E, else MULT_LAT. A start while busy restarts the count.
//   - Else if md_cnt!=0: decrement.
//   - MD_Busy = (md_cnt!=0), so it is high for exactly LAT cycles after the start edge.
//  mdstall = MD_Use_D && (MD_Start_E || md_cnt!=0).
//  Stall_F = Stall_D = Flush_E = lwstall | brstall | mdstall. This is combinational, with no added latency.
//  Forward and stall outputs are combinational from inputs and shadow state. MD_Busy is registered-derived.
// TESTING
//  1 add $3 in M (RegWrite_M), E reads Rs_Hazard=3 -> ForwardA_E=10; same reg also in W -> still 10
//  2 W-only write $5, Rt_Hazard=5 -> ForwardB_E=01; WriteReg=0 with RegWrite -> all forwards 00
//  3 lw $4 in E, D reads Rt_D=4 -> Stall_F=Stall_D=Flush_E=1 for 1 cycle, then ForwardB_E=01
//  4 beq, Rs_D=7, alu write $7 in E -> stall 1 cycle, then ForwardA_D=1 with no stall;
//    lw $7 -> 2 stall cycles
//  5 MD_Start_E with MD_Div_E=1 -> MD_Busy high exactly 10 cycles; mfhi held in D stalls
//    through the last busy cycle; mult start -> 5
//  6 reset low mid-divide (md_cnt=6) -> next edge: MD_Busy=0, all outputs 0, shadow cleared

Source files
------------

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard and forwarding controller for the 5-stage pipeline.
//   - Keeps a shadow copy of the M and W destination-register state, fed from
//     the E-stage control inputs.
//   - Returns EX-stage forwarding selects (ForwardA_E/ForwardB_E) and D-stage
//     compare forwarding (ForwardA_D/ForwardB_D).
//   - Detects load-use, branch/jr-operand and multiply/divide-use hazards and
//     drives Stall_F, Stall_D and Flush_E.
//   - Runs the busy counter of the multi-cycle multiply/divide unit (MD_Busy).
// Ports:
//   clk, reset (synchronous, active low)
//   D stage : Rs_D, Rt_D, Branch_D, Jr_D, MD_Use_D
//   E stage : Rs_Hazard, Rt_Hazard, WriteReg_E, RegWrite_E, MemtoReg_E,
//             MD_Start_E, MD_Div_E
//   outputs : ForwardA_E, ForwardB_E (00 RD1, 01 ResultW, 10 ALU_O_M),
//             ForwardA_D, ForwardB_D, Stall_F, Stall_D, Flush_E, MD_Busy
// All outputs are forced to 0 while reset is low.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs_D,
    input  logic [4:0] Rt_D,
    input  logic       Branch_D,
    input  logic       Jr_D,
    input  logic       MD_Use_D,
    input  logic [4:0] Rs_Hazard,
    input  logic [4:0] Rt_Hazard,
    input  logic [4:0] WriteReg_E,
    input  logic       RegWrite_E,
    input  logic       MemtoReg_E,
    input  logic       MD_Start_E,
    input  logic       MD_Div_E,
    output logic [1:0] ForwardA_E,
    output logic [1:0] ForwardB_E,
    output logic       ForwardA_D,
    output logic       ForwardB_D,
    output logic       Stall_F,
    output logic       Stall_D,
    output logic       Flush_E,
    output logic       MD_Busy
);

    localparam logic [5:0] MULT_LAT_C = 6'(MULT_LAT);
    localparam logic [5:0] DIV_LAT_C  = 6'(DIV_LAT);

    localparam logic [1:0] FWD_RD1 = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    // Register $0 is hard-wired, so a zero source never depends on a producer.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (src != 5'd0) && (dst == src);
    endfunction

    logic [4:0] write_reg_m_r;
    logic       reg_write_m_r;
    logic       mem_to_reg_m_r;
    logic [4:0] write_reg_w_r;
    logic       reg_write_w_r;
    logic [5:0] md_cnt_r;

    logic [1:0] fwd_a_e_s;
    logic [1:0] fwd_b_e_s;
    logic       fwd_a_d_s;
    logic       fwd_b_d_s;
    logic       lw_stall_s;
    logic       br_stall_s;
    logic       md_stall_s;
    logic       stall_s;

    // Shadow pipeline of destination-register state; E->M->W advance never stalls.
    always_ff @(posedge clk) begin
        if (!reset) begin
            write_reg_m_r  <= 5'd0;
            reg_write_m_r  <= 1'b0;
            mem_to_reg_m_r <= 1'b0;
            write_reg_w_r  <= 5'd0;
            reg_write_w_r  <= 1'b0;
        end else begin
            write_reg_m_r  <= WriteReg_E;
            reg_write_m_r  <= RegWrite_E;
            mem_to_reg_m_r <= MemtoReg_E;
            write_reg_w_r  <= write_reg_m_r;
            reg_write_w_r  <= reg_write_m_r;
        end
    end

    // Multiply/divide busy counter; a new start while busy restarts the count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            md_cnt_r <= 6'd0;
        end else if (MD_Start_E) begin
            md_cnt_r <= MD_Div_E ? DIV_LAT_C : MULT_LAT_C;
        end else if (md_cnt_r != 6'd0) begin
            md_cnt_r <= md_cnt_r - 6'd1;
        end else begin
            md_cnt_r <= md_cnt_r;
        end
    end

    // Forwarding selects; the younger M-stage result wins over W.
    always_comb begin
        fwd_a_e_s = FWD_RD1;
        fwd_b_e_s = FWD_RD1;
        if (reg_write_m_r && reg_match(write_reg_m_r, Rs_Hazard)) begin
            fwd_a_e_s = FWD_M;
        end else if (reg_write_w_r && reg_match(write_reg_w_r, Rs_Hazard)) begin
            fwd_a_e_s = FWD_W;
        end else begin
            fwd_a_e_s = FWD_RD1;
        end
        if (reg_write_m_r && reg_match(write_reg_m_r, Rt_Hazard)) begin
            fwd_b_e_s = FWD_M;
        end else if (reg_write_w_r && reg_match(write_reg_w_r, Rt_Hazard)) begin
            fwd_b_e_s = FWD_W;
        end else begin
            fwd_b_e_s = FWD_RD1;
        end
        fwd_a_d_s = reg_write_m_r && reg_match(write_reg_m_r, Rs_D);
        fwd_b_d_s = reg_write_m_r && reg_match(write_reg_m_r, Rt_D);
    end

    // Stall sources. Branches and jr resolve in D, so they also wait on an ALU
    // result still in E and on a load result still in M; jr reads only rs.
    always_comb begin
        lw_stall_s = RegWrite_E && MemtoReg_E &&
                     (reg_match(WriteReg_E, Rs_D) || reg_match(WriteReg_E, Rt_D));
        br_stall_s = 1'b0;
        if (Branch_D || Jr_D) begin
            br_stall_s = (RegWrite_E && reg_match(WriteReg_E, Rs_D)) ||
                         (reg_write_m_r && mem_to_reg_m_r && reg_match(write_reg_m_r, Rs_D));
        end else begin
            br_stall_s = 1'b0;
        end
        if (Branch_D) begin
            br_stall_s = br_stall_s ||
                         (RegWrite_E && reg_match(WriteReg_E, Rt_D)) ||
                         (reg_write_m_r && mem_to_reg_m_r && reg_match(write_reg_m_r, Rt_D));
        end else begin
            br_stall_s = br_stall_s;
        end
        md_stall_s = MD_Use_D && (MD_Start_E || (md_cnt_r != 6'd0));
        stall_s    = lw_stall_s || br_stall_s || md_stall_s;
    end

    // Output stage: everything is held at 0 while reset is asserted.
    always_comb begin
        if (!reset) begin
            ForwardA_E = 2'b00;
            ForwardB_E = 2'b00;
            ForwardA_D = 1'b0;
            ForwardB_D = 1'b0;
            Stall_F    = 1'b0;
            Stall_D    = 1'b0;
            Flush_E    = 1'b0;
            MD_Busy    = 1'b0;
        end else begin
            ForwardA_E = fwd_a_e_s;
            ForwardB_E = fwd_b_e_s;
            ForwardA_D = fwd_a_d_s;
            ForwardB_D = fwd_b_d_s;
            Stall_F    = stall_s;
            Stall_D    = stall_s;
            Flush_E    = stall_s;
            MD_Busy    = (md_cnt_r != 6'd0);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs_D, Rt_D, Rs_Hazard, Rt_Hazard, WriteReg_E;
    logic       Branch_D, Jr_D, MD_Use_D, RegWrite_E, MemtoReg_E, MD_Start_E, MD_Div_E;
    logic [1:0] ForwardA_E, ForwardB_E;
    logic       ForwardA_D, ForwardB_D, Stall_F, Stall_D, Flush_E, MD_Busy;

    int total = 0;
    int bad   = 0;

    logic [9:0] outs;
    logic [2:0] stalls;
    assign outs   = {ForwardA_E, ForwardB_E, ForwardA_D, ForwardB_D, Stall_F, Stall_D, Flush_E, MD_Busy};
    assign stalls = {Stall_F, Stall_D, Flush_E};

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset),
        .Rs_D(Rs_D), .Rt_D(Rt_D), .Branch_D(Branch_D), .Jr_D(Jr_D), .MD_Use_D(MD_Use_D),
        .Rs_Hazard(Rs_Hazard), .Rt_Hazard(Rt_Hazard), .WriteReg_E(WriteReg_E),
        .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E),
        .MD_Start_E(MD_Start_E), .MD_Div_E(MD_Div_E),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .ForwardA_D(ForwardA_D), .ForwardB_D(ForwardB_D),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_E(Flush_E), .MD_Busy(MD_Busy)
    );

    // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs_D = 5'd0; Rt_D = 5'd0; Branch_D = 1'b0; Jr_D = 1'b0; MD_Use_D = 1'b0;
        Rs_Hazard = 5'd0; Rt_Hazard = 5'd0; WriteReg_E = 5'd0;
        RegWrite_E = 1'b0; MemtoReg_E = 1'b0; MD_Start_E = 1'b0; MD_Div_E = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        tick();
        // hazardous inputs must still give all-zero outputs under reset
        WriteReg_E = 5'd3; RegWrite_E = 1'b1; MemtoReg_E = 1'b1; Rs_D = 5'd3;
        Branch_D = 1'b1; MD_Use_D = 1'b1; MD_Start_E = 1'b1;
        settle();
        total++;
        if (outs !== 10'd0) begin bad++; $display("FAIL reset_forced outs=%b want=%b", outs, 10'd0); end
        tick();
        clear_inputs();
        reset = 1'b1;
        tick();
        settle();
        total++;
        if (outs !== 10'd0) begin bad++; $display("FAIL reset_release outs=%b want=%b", outs, 10'd0); end
    endtask

    task automatic test_forward_m_w();
        clear_inputs();
        WriteReg_E = 5'd3; RegWrite_E = 1'b1;
        tick();
        Rs_Hazard = 5'd3;          // $3 now in M, another $3 write in E
        settle();
        total++;
        if (ForwardA_E !== 2'b10) begin bad++; $display("FAIL fwd_m ForwardA_E=%b want=10", ForwardA_E); end
        tick();
        RegWrite_E = 1'b0; WriteReg_E = 5'd0;  // $3 in both M and W
        Rs_D = 5'd3;
        settle();
        total++;
        if (ForwardA_E !== 2'b10) begin bad++; $display("FAIL fwd_m_prio ForwardA_E=%b want=10", ForwardA_E); end
        total++;
        if (ForwardA_D !== 1'b1) begin bad++; $display("FAIL fwd_a_d ForwardA_D=%b want=1", ForwardA_D); end
        tick();
        settle();                  // only W holds $3
        total++;
        if (ForwardA_E !== 2'b01) begin bad++; $display("FAIL fwd_w_a ForwardA_E=%b want=01", ForwardA_E); end
        total++;
        if (ForwardA_D !== 1'b0) begin bad++; $display("FAIL fwd_a_d_w ForwardA_D=%b want=0", ForwardA_D); end
    endtask

    task automatic test_forward_w_only_zero();
        clear_inputs();
        tick(); tick();
        WriteReg_E = 5'd5; RegWrite_E = 1'b1;
        tick();
        clear_inputs();
        tick();
        Rt_Hazard = 5'd5;
        settle();
        total++;
        if ({ForwardA_E, ForwardB_E} !== 4'b0001) begin
            bad++; $display("FAIL fwd_w_b fwdA_fwdB=%b want=0001", {ForwardA_E, ForwardB_E});
        end
        // writes to $0 in M and W, load to $0 in E, branch reading $0
        WriteReg_E = 5'd0; RegWrite_E = 1'b1;
        tick(); tick();
        MemtoReg_E = 1'b1; Branch_D = 1'b1; Rt_Hazard = 5'd0;
        settle();
        total++;
        if (outs !== 10'd0) begin bad++; $display("FAIL reg_zero outs=%b want=%b", outs, 10'd0); end
    endtask

    task automatic test_load_use();
        clear_inputs();
        tick(); tick();
        WriteReg_E = 5'd4; RegWrite_E = 1'b1; MemtoReg_E = 1'b1; Rt_D = 5'd4;
        settle();
        total++;
        if (stalls !== 3'b111) begin bad++; $display("FAIL lw_stall stalls=%b want=111", stalls); end
        tick();
        WriteReg_E = 5'd0; RegWrite_E = 1'b0; MemtoReg_E = 1'b0;  // bubble in E
        settle();
        total++;
        if (stalls !== 3'b000) begin bad++; $display("FAIL lw_release stalls=%b want=000", stalls); end
        tick();
        Rt_D = 5'd0; Rt_Hazard = 5'd4;  // consumer in E, lw in W
        settle();
        total++;
        if (ForwardB_E !== 2'b01) begin bad++; $display("FAIL lw_fwd ForwardB_E=%b want=01", ForwardB_E); end
    endtask

    task automatic test_branch();
        clear_inputs();
        tick(); tick();
        Branch_D = 1'b1; Rs_D = 5'd7; WriteReg_E = 5'd7; RegWrite_E = 1'b1;
        settle();
        total++;
        if (stalls !== 3'b111) begin bad++; $display("FAIL br_alu_stall stalls=%b want=111", stalls); end
        tick();
        WriteReg_E = 5'd0; RegWrite_E = 1'b0;
        settle();
        total++;
        if ({stalls, ForwardA_D} !== 4'b0001) begin
            bad++; $display("FAIL br_alu_fwd stalls_fwdAD=%b want=0001", {stalls, ForwardA_D});
        end
        tick(); tick();
        WriteReg_E = 5'd7; RegWrite_E = 1'b1; MemtoReg_E = 1'b1;
        settle();
        total++;
        if (stalls !== 3'b111) begin bad++; $display("FAIL br_lw_stall1 stalls=%b want=111", stalls); end
        tick();
        WriteReg_E = 5'd0; RegWrite_E = 1'b0; MemtoReg_E = 1'b0;
        settle();
        total++;
        if (stalls !== 3'b111) begin bad++; $display("FAIL br_lw_stall2 stalls=%b want=111", stalls); end
        tick();
        settle();
        total++;
        if ({stalls, ForwardA_D} !== 4'b0000) begin
            bad++; $display("FAIL br_lw_release stalls_fwdAD=%b want=0000", {stalls, ForwardA_D});
        end
        // jr reads rs only
        clear_inputs();
        tick(); tick();
        Jr_D = 1'b1; Rt_D = 5'd7; WriteReg_E = 5'd7; RegWrite_E = 1'b1;
        settle();
        total++;
        if (stalls !== 3'b000) begin bad++; $display("FAIL jr_rt_ignored stalls=%b want=000", stalls); end
        Rs_D = 5'd7;
        settle();
        total++;
        if (stalls !== 3'b111) begin bad++; $display("FAIL jr_rs_stall stalls=%b want=111", stalls); end
    endtask

    task automatic test_md();
        clear_inputs();
        tick(); tick();
        MD_Start_E = 1'b1; MD_Div_E = 1'b1; MD_Use_D = 1'b1;
        settle();
        total++;
        if ({MD_Busy, Stall_F} !== 2'b01) begin
            bad++; $display("FAIL md_start busy_stall=%b want=01", {MD_Busy, Stall_F});
        end
        for (int i = 1; i <= 11; i++) begin
            tick();
            MD_Start_E = 1'b0; MD_Div_E = 1'b0;
            settle();
            total++;
            if ({MD_Busy, Stall_F} !== ((i <= 10) ? 2'b11 : 2'b00)) begin
                bad++; $display("FAIL md_div cycle=%0d busy_stall=%b want=%b", i, {MD_Busy, Stall_F},
                                (i <= 10) ? 2'b11 : 2'b00);
            end
        end
        MD_Use_D = 1'b0;
        MD_Start_E = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            MD_Start_E = 1'b0;
            settle();
            total++;
            if (MD_Busy !== (i <= 5)) begin
                bad++; $display("FAIL md_mult cycle=%0d MD_Busy=%b want=%b", i, MD_Busy, (i <= 5));
            end
        end
        // restart a divide with a multiply two cycles in
        MD_Start_E = 1'b1; MD_Div_E = 1'b1;
        tick();
        MD_Start_E = 1'b0; MD_Div_E = 1'b0;
        tick();
        MD_Start_E = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            MD_Start_E = 1'b0;
            settle();
            total++;
            if (MD_Busy !== (i <= 5)) begin
                bad++; $display("FAIL md_restart cycle=%0d MD_Busy=%b want=%b", i, MD_Busy, (i <= 5));
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        tick(); tick();
        MD_Start_E = 1'b1; MD_Div_E = 1'b1; WriteReg_E = 5'd9; RegWrite_E = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            MD_Start_E = 1'b0; MD_Div_E = 1'b0;
        end
        // md_cnt is 6 here, $9 in M and W
        Rs_Hazard = 5'd9;
        settle();
        total++;
        if ({MD_Busy, ForwardA_E} !== 3'b110) begin
            bad++; $display("FAIL pre_reset busy_fwdA=%b want=110", {MD_Busy, ForwardA_E});
        end
        reset = 1'b0;
        settle();
        total++;
        if (outs !== 10'd0) begin bad++; $display("FAIL mid_reset_forced outs=%b want=%b", outs, 10'd0); end
        tick();
        reset = 1'b1;
        WriteReg_E = 5'd0; RegWrite_E = 1'b0;
        Rs_D = 5'd9; Rt_Hazard = 5'd9; MD_Use_D = 1'b1;
        settle();
        total++;
        if (outs !== 10'd0) begin bad++; $display("FAIL mid_reset_cleared outs=%b want=%b", outs, 10'd0); end
        tick();
        settle();
        total++;
        if (outs !== 10'd0) begin bad++; $display("FAIL mid_reset_after outs=%b want=%b", outs, 10'd0); end
    endtask

    initial begin
        test_reset();
        test_forward_m_w();
        test_forward_w_only_zero();
        test_load_use();
        test_branch();
        test_md();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
